// File: rtl/mant_mul_seq.sv
// Shift-and-add mantissa multiplier: one shared 2*MW-bit add per clock, MW steps per product.
// Latency MW cycles from accept to done_valid; result held in DONE until done_ready, no operand queueing.
module mant_mul_seq #(
    parameter int MW = 24
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start_valid,
    output logic            o_start_ready,
    input  logic [MW-1:0]   i_a_in,
    input  logic [MW-1:0]   i_b_in,
    output logic            o_done_valid,
    input  logic            i_done_ready,
    output logic [2*MW-1:0] o_prod,
    output logic            o_norm,
    output logic            o_busy
);

    localparam int PW = 2 * MW;
    localparam int CW = $clog2(MW);
    localparam logic [CW-1:0] LAST = CW'(MW - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [PW-1:0]   r_acc;
    logic [PW-1:0]   r_mcand;
    logic [PW-1:0]   r_prod;
    logic [MW-1:0]   r_mplr;
    logic [CW-1:0]   r_cnt;

    logic [PW-1:0]   w_addend;
    logic [PW-1:0]   w_sum;
    logic            w_carry;
    logic            w_accept;
    logic            w_last;

    // The single shared adder; its carry-out can never be set for in-range operands.
    assign w_addend           = r_mplr[0] ? r_mcand : '0;
    assign {w_carry, w_sum}   = {1'b0, r_acc} + {1'b0, w_addend};

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_last      = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start_valid) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_RUN;
                end
            end
            S_RUN: begin
                if (r_cnt == LAST) begin
                    w_last      = 1'b1;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                if (i_done_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_acc   <= '0;
            r_mcand <= '0;
            r_mplr  <= '0;
            r_cnt   <= '0;
            r_prod  <= '0;
        end else if (w_accept) begin
            r_mcand <= {{MW{1'b0}}, i_a_in};
            r_mplr  <= i_b_in;
            r_acc   <= '0;
            r_cnt   <= '0;
        end else if (r_state == S_RUN) begin
            r_acc   <= w_sum;
            r_mcand <= r_mcand << 1;
            r_mplr  <= r_mplr >> 1;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_prod <= w_sum;
            end
        end
    end

    // Handshake outputs come straight from the state register.
    assign o_start_ready = (r_state == S_IDLE);
    assign o_done_valid  = (r_state == S_DONE);
    assign o_busy        = (r_state != S_IDLE);
    assign o_prod        = r_prod;
    assign o_norm        = r_prod[PW-1];

    a_no_carry: assert property (@(posedge i_clk) disable iff (i_rst)
        (r_state == S_RUN) |-> !w_carry);

endmodule

// File: tb/tb_mant_mul_seq.sv
// Bench for mant_mul_seq: timestamp-based reference model checked every cycle, plus directed literal vectors.
module tb_mant_mul_seq;

    localparam int MW = 24;

    logic          clk = 1'b0;
    logic          rst;
    logic          start_valid;
    logic          start_ready;
    logic [23:0]   a_in;
    logic [23:0]   b_in;
    logic          done_valid;
    logic          done_ready;
    logic [47:0]   prod;
    logic          norm;
    logic          busy;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mant_mul_seq #(.MW(MW)) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_start_valid (start_valid),
        .o_start_ready (start_ready),
        .i_a_in        (a_in),
        .i_b_in        (b_in),
        .o_done_valid  (done_valid),
        .i_done_ready  (done_ready),
        .o_prod        (prod),
        .o_norm        (norm),
        .o_busy        (busy)
    );

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic logic [47:0] mul(input logic [23:0] a, input logic [23:0] b);
        logic [47:0] x;
        logic [47:0] y;
        x = {24'b0, a};
        y = {24'b0, b};
        return x * y;
    endfunction

    // Model: an operation is in flight from its accept edge until the transfer edge;
    // the result is due from MW edges after the accept edge onward.
    bit          m_infl = 1'b0;
    int          m_acc_edge = 0;
    logic [47:0] m_exp = '0;
    int          edge_n = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_infl = 1'b0;
        end else if (!m_infl && start_valid) begin
            m_infl     = 1'b1;
            m_acc_edge = edge_n + 1;
            m_exp      = mul(a_in, b_in);
        end else if (m_infl && edge_n >= m_acc_edge + MW && done_ready) begin
            m_infl = 1'b0;
        end
        edge_n++;
    end

    always @(negedge clk) begin
        bit exp_done;
        if (edge_n > 0) begin
            exp_done = m_infl && (edge_n >= m_acc_edge + MW);
            chk("m_start_ready", {47'b0, start_ready}, {47'b0, !m_infl});
            chk("m_busy",        {47'b0, busy},        {47'b0, m_infl});
            chk("m_done_valid",  {47'b0, done_valid},  {47'b0, exp_done});
            if (exp_done) begin
                chk("m_prod", prod, m_exp);
                chk("m_norm", {47'b0, norm}, {47'b0, m_exp[47]});
            end
        end
    end

    // Called at a negedge; the next posedge accepts the operands.
    task automatic issue(input logic [23:0] a, input logic [23:0] b);
        start_valid = 1'b1;
        a_in        = a;
        b_in        = b;
    endtask

    // Consumes the accept edge, then waits for done_valid and checks latency and result.
    task automatic wait_done(input logic [47:0] exp, input logic exp_norm,
                             input bit scramble, input string nm);
        int lat;
        bit got;
        lat = 0;
        got = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        while (!got && lat < 100) begin
            if (scramble) begin
                a_in = 24'($urandom);
                b_in = 24'($urandom);
            end
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (done_valid) got = 1'b1;
        end
        if (!got) begin
            chk({nm, "_timeout"}, 48'd0, 48'd1);
        end else begin
            chk({nm, "_latency"}, 48'(lat), 48'd24);
            chk({nm, "_prod"}, prod, exp);
            chk({nm, "_norm"}, {47'b0, norm}, {47'b0, exp_norm});
        end
    endtask

    task automatic release_done(input string nm);
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        chk({nm, "_idle"}, {47'b0, start_ready}, 48'd1);
    endtask

    initial begin
        int seen;
        rst         = 1'b1;
        start_valid = 1'($urandom);
        done_ready  = 1'($urandom);
        a_in        = 24'($urandom);
        b_in        = 24'($urandom);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_start_ready", {47'b0, start_ready}, 48'd1);
        chk("rst_done_valid",  {47'b0, done_valid},  48'd0);
        chk("rst_busy",        {47'b0, busy},        48'd0);
        chk("rst_prod",        prod,                 48'd0);
        rst         = 1'b0;
        start_valid = 1'b0;
        done_ready  = 1'b0;
        @(negedge clk);

        issue(24'hC00000, 24'hC00000);
        wait_done(48'h900000000000, 1'b1, 1'b0, "sq1p5");
        release_done("sq1p5");

        issue(24'h800000, 24'h800000);
        wait_done(48'h400000000000, 1'b0, 1'b0, "sq1p0");
        release_done("sq1p0");

        issue(24'hFFFFFF, 24'hFFFFFF);
        wait_done(48'hFFFFFE000001, 1'b1, 1'b0, "sqmax");
        release_done("sqmax");

        // Backpressure with a new request waiting.
        issue(24'h123456, 24'h000002);
        wait_done(48'h0000002468AC, 1'b0, 1'b0, "bp_first");
        issue(24'h400000, 24'h000003);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("bp_prod_held",   prod,                  48'h0000002468AC);
            chk("bp_start_ready", {47'b0, start_ready},  48'd0);
            chk("bp_done_valid",  {47'b0, done_valid},   48'd1);
        end
        done_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        done_ready = 1'b0;
        chk("bp_idle_after_xfer", {47'b0, start_ready}, 48'd1);
        wait_done(48'h000000C00000, 1'b0, 1'b0, "bp_second");
        release_done("bp_second");

        // Reset at RUN step 10.
        issue(24'hFFFFFF, 24'hFFFFFF);
        @(posedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midrst_start_ready", {47'b0, start_ready}, 48'd1);
        chk("midrst_busy",        {47'b0, busy},        48'd0);
        seen = 0;
        repeat (30) begin
            @(negedge clk);
            if (done_valid) seen++;
        end
        chk("midrst_no_done", 48'(seen), 48'd0);
        issue(24'h800001, 24'h000003);
        wait_done(48'h000001800003, 1'b0, 1'b0, "after_rst");
        release_done("after_rst");

        // Operands churn during RUN; zero operand keeps full latency.
        issue(24'h000000, 24'hABCDEF);
        wait_done(48'h000000000000, 1'b0, 1'b1, "hygiene");
        release_done("hygiene");

        // done_ready already high when DONE is entered.
        done_ready = 1'b1;
        issue(24'h000003, 24'h000005);
        wait_done(48'h00000000000F, 1'b0, 1'b0, "early_rdy");
        @(posedge clk);
        @(negedge clk);
        chk("early_rdy_xfer", {47'b0, done_valid}, 48'd0);
        done_ready = 1'b0;

        repeat (3) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
